// File: rtl/spi_sram_pkg.sv
// Shared opcodes, FSM state encoding and command-word helpers for the
// SPI single-port RAM arbiter/sequencer.
package spi_sram_pkg;

   localparam int CMD_W = 10;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_CMD  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_CMD,
      RD_WAIT,
      DONE
   } state_t;

   function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] op, input logic [7:0] payload);
      return {op, payload};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: purely combinational one-hot grant.
// i_ptr names the requester that wins when both request.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11)
         o_gnt = i_ptr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/spi_sram_arb.sv
// Arbitrates two requesters onto the SPI RAM command port and expands each
// read/write into its 10-bit command-word sequence; read data is returned on done.
module spi_sram_arb
   import spi_sram_pkg::*;
#(
   parameter int ADDR_SIZE  = 8,
   parameter int RD_TIMEOUT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           i_req,
   input  logic [1:0]           i_we,
   input  logic [ADDR_SIZE-1:0] i_addr0,
   input  logic [ADDR_SIZE-1:0] i_addr1,
   input  logic [7:0]           i_wdata0,
   input  logic [7:0]           i_wdata1,
   output logic [1:0]           o_gnt,
   output logic [1:0]           o_done,
   output logic [7:0]           o_rdata,
   output logic                 o_err,
   output logic [CMD_W-1:0]     o_ram_din,
   output logic                 o_ram_rx_valid,
   input  logic [7:0]           i_ram_dout,
   input  logic                 i_ram_tx_valid
);

   state_t            r_state, w_next;
   logic              r_ptr;
   logic [1:0]        r_gnt;
   logic [1:0]        r_done;
   logic              r_err;
   logic [7:0]        r_rdata;
   logic [7:0]        r_wdata;
   logic [3:0]        r_cnt;
   logic [CMD_W-1:0]  r_din, w_cmd;
   logic              r_rx_valid, w_cmd_vld;

   logic [1:0]        w_arb_gnt;
   logic              w_we_sel;
   logic [7:0]        w_addr_sel;
   logic [7:0]        w_wdata_sel;
   logic              w_timeout;

   rr_arb2 u_arb (
      .i_req (i_req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt)
   );

   assign w_we_sel    = |(w_arb_gnt & i_we);
   assign w_addr_sel  = w_arb_gnt[1] ? 8'(i_addr1) : 8'(i_addr0);
   assign w_wdata_sel = w_arb_gnt[1] ? i_wdata1 : i_wdata0;
   assign w_timeout   = (r_state == RD_WAIT) && !i_ram_tx_valid
                        && (r_cnt == 4'(RD_TIMEOUT - 1));

   // Command word is computed for the state being entered so it is
   // registered alongside that state.
   always_comb begin
      w_next    = r_state;
      w_cmd     = '0;
      w_cmd_vld = 1'b0;
      case (r_state)
         IDLE: begin
            if (|i_req) begin
               w_next    = w_we_sel ? WR_ADDR : RD_ADDR;
               w_cmd     = mk_cmd(w_we_sel ? OP_WR_ADDR : OP_RD_ADDR, w_addr_sel);
               w_cmd_vld = 1'b1;
            end
         end
         WR_ADDR: begin
            w_next    = WR_DATA;
            w_cmd     = mk_cmd(OP_WR_DATA, r_wdata);
            w_cmd_vld = 1'b1;
         end
         WR_DATA: w_next = DONE;
         RD_ADDR: begin
            w_next    = RD_CMD;
            w_cmd     = mk_cmd(OP_RD_CMD, 8'h00);
            w_cmd_vld = 1'b1;
         end
         RD_CMD:  w_next = RD_WAIT;
         RD_WAIT: if (i_ram_tx_valid || w_timeout) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= 1'b0;
         r_gnt      <= 2'b00;
         r_done     <= 2'b00;
         r_err      <= 1'b0;
         r_rdata    <= 8'h00;
         r_wdata    <= 8'h00;
         r_cnt      <= 4'd0;
         r_din      <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_din      <= w_cmd;
         r_rx_valid <= w_cmd_vld;
         r_done     <= 2'b00;
         r_err      <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|i_req) begin
                  r_gnt   <= w_arb_gnt;
                  r_ptr   <= w_arb_gnt[0];
                  r_wdata <= w_wdata_sel;
               end
            end
            WR_DATA: r_done <= r_gnt;
            RD_CMD:  r_cnt  <= 4'd0;
            RD_WAIT: begin
               if (i_ram_tx_valid) begin
                  r_rdata <= i_ram_dout;
                  r_done  <= r_gnt;
               end else if (w_timeout) begin
                  r_rdata <= 8'h00;
                  r_err   <= 1'b1;
                  r_done  <= r_gnt;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            DONE:    r_gnt <= 2'b00;
            default: ;
         endcase
      end
   end

   assign o_gnt          = r_gnt;
   assign o_done         = r_done;
   assign o_err          = r_err;
   assign o_rdata        = r_rdata;
   assign o_ram_din      = r_din;
   assign o_ram_rx_valid = r_rx_valid;

endmodule

// File: doc/spi_sram_arb.md
Name: spi_sram_arb

Overview:
Two-requester arbiter and command sequencer in front of the SPI single-port RAM block.
- Each requester issues a simple read or write transaction: we, addr, wdata.
- The block grants one requester round-robin and expands the transaction into the RAM's 10-bit command words on din/rx_valid: address-load plus data for a write, address-load plus read-command for a read.
- For reads it collects dout on tx_valid and returns it to the granted requester.
- It sits between the SPI slave front-end (requester 0) and the on-chip test/init engine (requester 1).

Parameters:
- ADDR_SIZE, 8, RAM address width; must match the RAM's ADDR_SIZE.
- RD_TIMEOUT, 4, maximum cycles spent in RD_WAIT before the read is aborted with err; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request per requester; held high until that requester's done pulse
- we  in  2  per-requester transaction type: 1=write, 0=read
- addr0, addr1  in  ADDR_SIZE each  per-requester address
- wdata0, wdata1  in  8 each  per-requester write data
- gnt  out  2  one-hot grant; high from acceptance through the DONE cycle
- done  out  2  one-cycle completion pulse to the granted requester
- rdata  out  8  read result; valid while done is high for a read
- err  out  1  one-cycle pulse together with done when a read times out
- ram_din  out  10  command word to RAM: {opcode[1:0], payload[7:0]}
- ram_rx_valid  out  1  command strobe to RAM
- ram_dout  in  8  RAM read data
- ram_tx_valid  in  1  RAM read-data valid

Behaviour:
- Reset, asynchronous active-low, takes effect immediately:
  - state=IDLE, rr_ptr=0.
  - gnt=0, done=0, err=0, rdata=8'h00.
  - ram_din=10'h000, ram_rx_valid=0.
- All outputs are registered.
- ram_din=0 and ram_rx_valid=0 in every state except WR_ADDR, WR_DATA, RD_ADDR and RD_CMD.
- Opcodes: 00 write-address, 01 write-data, 10 read-address, 11 read-command.
- States and transitions:
  - IDLE: if any req bit is set, the arbiter picks a winner and the block latches that requester's we/addr/wdata and sets its gnt bit. Next state is WR_ADDR if we=1, else RD_ADDR. If no req, stay in IDLE.
  - WR_ADDR: drive {00,addr}, rx_valid=1, then go to WR_DATA.
  - WR_DATA: drive {01,wdata}, rx_valid=1, then go to DONE.
  - RD_ADDR: drive {10,addr}, rx_valid=1, then go to RD_CMD.
  - RD_CMD: drive {11,8'h00}, rx_valid=1, then go to RD_WAIT.
  - RD_WAIT: clear the timeout counter on entry.
    - If ram_tx_valid=1: rdata<=ram_dout, go to DONE.
    - Else if the counter reaches RD_TIMEOUT-1: rdata<=8'h00, set the err pulse, go to DONE.
  - DONE: done[winner]=1 for exactly one cycle, gnt held this cycle, then gnt<=0 and go to IDLE.
- Latency, counted from the IDLE cycle in which req is sampled:
  - Write: done asserted in cycle 3.
  - Read, nominal: done asserted in cycle 4, because the RAM returns tx_valid the cycle after RD_CMD.
- Arbitration:
  - Round-robin: rr_ptr names the requester with priority.
  - On each grant, rr_ptr <= ~winner.
  - Simultaneous requests are served alternately.
- Back-to-back:
  - There is a mandatory single IDLE cycle between transactions.
  - A req still high in that IDLE cycle is treated as a new request.
  - Requesters must drop req in their done cycle to avoid a repeat.
- Inputs are sampled only at grant; changes to we/addr/wdata mid-transaction are ignored.
- ram_tx_valid outside RD_WAIT is ignored.
- Each transaction re-sends its address, so leftover RAM address state is harmless. This covers a reset mid-operation that aborts a transaction with a partial RAM command sequence.

Decomposition:
- spi_sram_pkg holds:
  - the opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_CMD;
  - the state enum IDLE/WR_ADDR/WR_DATA/RD_ADDR/RD_CMD/RD_WAIT/DONE;
  - the 10-bit command word width.
- One sub-module, rr_arb2: a two-input round-robin arbiter.
  - Inputs: req[1:0], ptr.
  - Output: one-hot grant, combinational.
  - The parent registers the grant and the pointer.

Test Plan:
- Write: req=01, we0=1, addr0=8'h3C, wdata0=8'hA5 -> ram_din=10'h03C then 10'h1A5 with rx_valid high on consecutive cycles; done=01 in cycle 3; gnt=01 throughout.
- Read-back: after the write, req=01, we0=0, addr0=8'h3C -> ram_din=10'h23C, then 10'h300; done=01 in cycle 4 with rdata=8'hA5, err=0.
- Contention: req=11 held, both reads, rr_ptr=0 -> grants in order 01, 10, 01; each done pulse goes to the matching requester; exactly one IDLE cycle between transactions.
- Timeout: read with ram_tx_valid forced 0 -> after RD_TIMEOUT=4 cycles in RD_WAIT, done and err pulse together and rdata=8'h00; a following write completes normally.
- Reset mid-read: assert rst_n=0 during RD_CMD -> gnt, ram_rx_valid and ram_din are 0 immediately (asynchronously); after release, a new read of the same address returns correct data.
- Input stability: change addr0 from 8'h10 to 8'h20 during WR_ADDR -> RAM still receives address 8'h10; done as normal.
